aes_mixcol_engine: RTL and testbench

Parametrised, sequential AES MixColumns / InvMixColumns unit for the round datapath. It accepts a 128-bit state over a valid/ready handshake and latches the direction (forward or inverse). It then transforms COLS_PER_CYCLE columns per clock and returns the result over a second valid/ready handshake. It replaces the combinational forward-only mixer where area must trade against latency and where the decrypt path needs the inverse transform.

---
 rtl/aes_mixcol_engine.sv | 117 +++++++++++
 tb/tb_aes_mixcol_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mixcol_engine.sv
// AES MixColumns / InvMixColumns engine.
// Accepts a 128-bit state, then transforms COLS_PER_CYCLE columns per clock in
// place. The finished state is held on out_data until the consumer takes it.

// One column of the transform. The forward and inverse paths share the xtime chain.
module aes_mixcol_col (
  input  logic        inv,
  input  logic [31:0] a,
  output logic [31:0] b
);
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] x1 [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];

  // Build the 1/2/4/8 multiples of each row byte, then combine them per row.
  // 9 = 8+1, 11 = 8+2+1, 13 = 8+4+1, 14 = 8+4+2.
  always_comb begin
    b = '0;
    for (int i = 0; i < 4; i++) begin
      x1[i] = a[31-8*i -: 8];
      x2[i] = xt(x1[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv)
        b[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                       ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ x1[(i+1)%4])
                       ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ x1[(i+2)%4])
                       ^ (x8[(i+3)%4] ^ x1[(i+3)%4]);
      else
        b[31-8*i -: 8] = x2[i] ^ x2[(i+1)%4] ^ x1[(i+1)%4]
                       ^ x1[(i+2)%4] ^ x1[(i+3)%4];
    end
  end
endmodule

module aes_mixcol_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // A step of 4 wraps to 0 in two bits; harmless, since BUSY is left on the first cycle.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $fatal(1, "aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic              mode;
  // Column c is stored at packed index 3-c, so that column 0 sits in bits [127:96].
  logic [3:0][31:0]  work;

  logic [COLS_PER_CYCLE-1:0][1:0]  idx;
  logic [COLS_PER_CYCLE-1:0][31:0] col_in;
  logic [COLS_PER_CYCLE-1:0][31:0] col_out;

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign idx[j]    = 2'd3 - cnt - 2'(j);
    assign col_in[j] = work[idx[j]];
    aes_mixcol_col u_col (
      .inv (mode),
      .a   (col_in[j]),
      .b   (col_out[j])
    );
  end

  // Control FSM and in-place column write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      mode  <= 1'b0;
      work  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_data;
          mode  <= in_inv;
          cnt   <= 2'd0;
          state <= BUSY;
        end
        BUSY: begin
          for (int j = 0; j < COLS_PER_CYCLE; j++) work[idx[j]] <= col_out[j];
          cnt <= cnt + STEP;
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;
endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Self-checking bench for aes_mixcol_engine: three instances (1, 2 and 4
// columns per cycle) are checked against a generic GF(2^8) multiply model.
module tb_aes_mixcol_engine;
  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] INV_IN   = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] INV_OUT  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  logic         clk = 0;
  logic         rst_n = 0;
  logic [2:0]   in_valid = '0;
  logic [2:0]   in_ready;
  logic [2:0]   in_inv = '0;
  logic [127:0] in_data [3];
  logic [2:0]   out_valid;
  logic [2:0]   out_ready = '1;
  logic [127:0] out_data [3];

  int n_chk = 0;
  int n_err = 0;
  int acc_cnt [3];
  int out_cnt [3];
  logic [127:0] q [3][$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    aes_mixcol_engine #(.COLS_PER_CYCLE(1 << k)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_inv    (in_inv[k]),
      .in_data   (in_data[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] x, input logic inv);
    logic [127:0] y = '0;
    logic [7:0] m [4];
    logic [7:0] a [4];
    if (inv) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    else     begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        y[127-32*c-8*r -: 8] = gmul(m[0], a[r]) ^ gmul(m[1], a[(r+1)%4])
                             ^ gmul(m[2], a[(r+2)%4]) ^ gmul(m[3], a[(r+3)%4]);
    end
    return y;
  endfunction

  // Scoreboard: push the model result on every input handshake, pop and compare on
  // every output handshake. Handshakes are judged at the negedge before the edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) q[k].delete();
      else begin
        if (out_valid[k] && out_ready[k]) begin
          if (q[k].size() == 0) chk($sformatf("spurious_out[%0d]", k), 128'(q[k].size()), 128'd1);
          else begin
            chk($sformatf("out_data[%0d]", k), out_data[k], q[k].pop_front());
            out_cnt[k]++;
          end
        end
        if (in_valid[k] && in_ready[k]) begin
          q[k].push_back(ref_mix(in_data[k], in_inv[k]));
          acc_cnt[k]++;
        end
      end
    end
  end

  // Present a state and hold it until accepted; returns at accept edge + 1.
  task automatic send(input int k, input logic [127:0] d, input logic inv);
    int t = 0;
    in_valid[k] = 1'b1; in_data[k] = d; in_inv[k] = inv;
    @(negedge clk);
    while (!in_ready[k] && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk($sformatf("accept_timeout[%0d]", k), 128'(in_ready[k]), 128'd1);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  // Wait (bounded) for a result with out_ready high; returns after the output edge + 1.
  task automatic recv(input int k, output logic [127:0] d);
    int t = 0;
    out_ready[k] = 1'b1;
    @(negedge clk);
    while (!out_valid[k] && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) chk($sformatf("out_timeout[%0d]", k), 128'(out_valid[k]), 128'd1);
    d = out_data[k];
    @(posedge clk); #1;
  endtask

  // Directed transfer checking exact latency, result and the return of in_ready.
  task automatic lat_test(input int k, input logic [127:0] d, input logic inv, input logic [127:0] exp);
    int lat = 4 >> k;
    out_ready[k] = 1'b1;
    in_valid[k] = 1'b1; in_data[k] = d; in_inv[k] = inv;
    @(negedge clk);
    chk($sformatf("idle_ready[%0d]", k), 128'(in_ready[k]), 128'd1);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("latency[%0d] c%0d", k, i), 128'(out_valid[k]), 128'(i == lat));
      if (i < lat) chk($sformatf("busy_ready[%0d]", k), 128'(in_ready[k]), 128'd0);
    end
    chk($sformatf("result[%0d]", k), out_data[k], exp);
    chk($sformatf("done_ready[%0d]", k), 128'(in_ready[k]), 128'd0);
    @(posedge clk); @(negedge clk);
    chk($sformatf("ready_after_out[%0d]", k), 128'(in_ready[k]), 128'd1);
    chk($sformatf("valid_after_out[%0d]", k), 128'(out_valid[k]), 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] x, y, z;
    int t;
    for (int k = 0; k < 3; k++) begin in_data[k] = '0; acc_cnt[k] = 0; out_cnt[k] = 0; end

    // Reset state
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k), 128'(in_ready[k]), 128'd1);
      chk($sformatf("rst_out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("rst_out_data[%0d]", k), out_data[k], 128'd0);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      // FIPS forward and inverse vectors with latency
      lat_test(k, FIPS_IN, 1'b0, FIPS_OUT);
      lat_test(k, INV_IN, 1'b1, INV_OUT);

      // Backpressure: result held for 10 cycles, input pulses ignored
      out_ready[k] = 1'b0;
      send(k, FIPS_IN, 1'b0);
      t = 0;
      @(negedge clk);
      while (!out_valid[k] && t < 20) begin @(negedge clk); t++; end
      chk($sformatf("bp_valid_rise[%0d]", k), 128'(out_valid[k]), 128'd1);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        in_valid[k] = 1'($urandom_range(0, 1));
        in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
        in_inv[k]   = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk($sformatf("bp_data[%0d]", k), out_data[k], FIPS_OUT);
        chk($sformatf("bp_in_ready[%0d]", k), 128'(in_ready[k]), 128'd0);
        chk($sformatf("bp_out_valid[%0d]", k), 128'(out_valid[k]), 128'd1);
      end
      @(posedge clk); #1;
      in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      @(posedge clk); @(negedge clk);
      chk($sformatf("bp_release_ready[%0d]", k), 128'(in_ready[k]), 128'd1);
      chk($sformatf("bp_release_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
      @(posedge clk); #1;

      // Mode latching: in_inv toggles while busy
      in_valid[k] = 1'b1; in_data[k] = FIPS_IN; in_inv[k] = 1'b0;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      for (int i = 0; i < (4 >> k); i++) begin in_inv[k] = ~in_inv[k]; @(posedge clk); #1; end
      recv(k, y);
      chk($sformatf("mode_latch[%0d]", k), y, FIPS_OUT);

      // Reset during BUSY
      send(k, INV_IN, 1'b1);
      rst_n = 1'b0;
      #1;
      chk($sformatf("midrst_out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("midrst_in_ready[%0d]", k), 128'(in_ready[k]), 128'd1);
      chk($sformatf("midrst_out_data[%0d]", k), out_data[k], 128'd0);
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      lat_test(k, FIPS_IN, 1'b0, FIPS_OUT);

      // Forward then inverse returns the original state
      x = {$urandom, $urandom, $urandom, $urandom};
      send(k, x, 1'b0);
      recv(k, y);
      send(k, y, 1'b1);
      recv(k, z);
      chk($sformatf("identity[%0d]", k), z, x);

      // Randomised stream with random gaps on both handshakes
      acc_cnt[k] = 0; out_cnt[k] = 0;
      t = 0;
      while (acc_cnt[k] < 25 && t < 2000) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
        in_inv[k]    = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
        t++;
      end
      in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      t = 0;
      while (q[k].size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
      chk($sformatf("stream_count[%0d]", k), 128'(out_cnt[k]), 128'(acc_cnt[k]));
      chk($sformatf("stream_accepts[%0d]", k), 128'(acc_cnt[k] >= 25), 128'd1);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
